// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry saturating counters and a non-speculative
// global history register. Index selection is either bimodal or gshare.
module branch_predictor #(
  parameter int XLEN      = 32,
  parameter int ENTRIES   = 16,
  parameter int CNTR_BITS = 2,
  parameter int GHR_BITS  = 4,
  parameter int GSHARE    = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [XLEN-1:0]     if_pc_i,
  output logic                pred_hit_o,
  output logic                pred_taken_o,
  output logic [XLEN-1:0]     pred_target_o,
  output logic [GHR_BITS-1:0] pred_ghr_o,
  input  logic                ex_valid_i,
  input  logic [XLEN-1:0]     ex_pc_i,
  input  logic [3:0]          ex_cfuop_i,
  input  logic                ex_taken_i,
  input  logic [XLEN-1:0]     ex_target_i,
  input  logic [GHR_BITS-1:0] ex_ghr_i
);

  localparam int IW = $clog2(ENTRIES);
  localparam int TW = XLEN - IW - 2;

  localparam logic [3:0] OP_BEQ  = 4'd1;
  localparam logic [3:0] OP_BGEU = 4'd6;
  localparam logic [3:0] OP_JAL  = 4'd7;
  localparam logic [3:0] OP_JALR = 4'd8;

  localparam logic [CNTR_BITS-1:0] CNTR_MAX = '1;
  localparam logic [CNTR_BITS-1:0] CNTR_WT  = CNTR_BITS'(1) << (CNTR_BITS - 1);
  localparam logic [CNTR_BITS-1:0] CNTR_WNT = CNTR_WT - CNTR_BITS'(1);

  logic                 valid_reg  [ENTRIES];
  logic                 jump_reg   [ENTRIES];
  logic [TW-1:0]        tag_reg    [ENTRIES];
  logic [XLEN-1:0]      target_reg [ENTRIES];
  logic [CNTR_BITS-1:0] cntr_reg   [ENTRIES];
  logic [GHR_BITS-1:0]  ghr_reg;
  logic [GHR_BITS-1:0]  ghr_next;

  logic [IW-1:0]        lk_hash, up_hash, lk_idx, up_idx;
  logic [TW-1:0]        lk_tag, up_tag;
  logic                 is_cond, is_jump, up_hit;
  logic                 meta_we, meta_jump, target_we, cntr_we;
  logic [CNTR_BITS-1:0] cntr_cur, cntr_new;
  logic                 unused_bits;

  // gshare folds history into the low index bits only; tags stay pure PC bits
  assign lk_hash = (GSHARE != 0) ? IW'(ghr_reg)  : '0;
  assign up_hash = (GSHARE != 0) ? IW'(ex_ghr_i) : '0;
  assign lk_idx  = if_pc_i[IW+1:2] ^ lk_hash;
  assign up_idx  = ex_pc_i[IW+1:2] ^ up_hash;
  assign lk_tag  = if_pc_i[XLEN-1:IW+2];
  assign up_tag  = ex_pc_i[XLEN-1:IW+2];

  assign pred_hit_o    = valid_reg[lk_idx] && (tag_reg[lk_idx] == lk_tag);
  assign pred_taken_o  = pred_hit_o && (jump_reg[lk_idx] || cntr_reg[lk_idx][CNTR_BITS-1]);
  assign pred_target_o = pred_taken_o ? target_reg[lk_idx] : (if_pc_i + XLEN'(4));
  assign pred_ghr_o    = ghr_reg;

  generate
    if (GHR_BITS == 1) begin : g_ghr1
      assign ghr_next = ex_taken_i;
    end else begin : g_ghrn
      assign ghr_next = {ex_ghr_i[GHR_BITS-2:0], ex_taken_i};
    end
  endgenerate

  assign unused_bits = ^{ex_pc_i[1:0], ex_ghr_i};

  always_comb begin
    is_cond   = ex_valid_i && (ex_cfuop_i >= OP_BEQ) && (ex_cfuop_i <= OP_BGEU);
    is_jump   = ex_valid_i && ((ex_cfuop_i == OP_JAL) || (ex_cfuop_i == OP_JALR));
    up_hit    = valid_reg[up_idx] && (tag_reg[up_idx] == up_tag);
    cntr_cur  = cntr_reg[up_idx];
    meta_we   = 1'b0;
    meta_jump = 1'b0;
    target_we = 1'b0;
    cntr_we   = 1'b0;
    cntr_new  = cntr_cur;
    if (is_jump) begin
      meta_we   = 1'b1;
      meta_jump = 1'b1;
      target_we = 1'b1;
    end else if (is_cond) begin
      if (up_hit) begin
        cntr_we   = 1'b1;
        target_we = ex_taken_i;
        if (ex_taken_i)
          cntr_new = (cntr_cur == CNTR_MAX) ? cntr_cur : cntr_cur + CNTR_BITS'(1);
        else
          cntr_new = (cntr_cur == '0) ? cntr_cur : cntr_cur - CNTR_BITS'(1);
      end else if (ex_taken_i) begin
        meta_we   = 1'b1;
        target_we = 1'b1;
        cntr_we   = 1'b1;
        cntr_new  = CNTR_WT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_reg[i] <= 1'b0;
        cntr_reg[i]  <= CNTR_WNT;
      end
      ghr_reg <= '0;
    end else begin
      if (meta_we) valid_reg[up_idx] <= 1'b1;
      if (cntr_we) cntr_reg[up_idx]  <= cntr_new;
      if (is_cond) ghr_reg           <= ghr_next;
    end
  end

  // Payload fields need no reset: they are only observed behind a valid bit
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (meta_we) begin
        tag_reg[up_idx]  <= up_tag;
        jump_reg[up_idx] <= meta_jump;
      end
      if (target_we) target_reg[up_idx] <= ex_target_i;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed table-driven bench for branch_predictor (default parameters, bimodal).
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc_i;
  logic        pred_hit_o, pred_taken_o;
  logic [31:0] pred_target_o;
  logic [3:0]  pred_ghr_o;
  logic        ex_valid_i;
  logic [31:0] ex_pc_i;
  logic [3:0]  ex_cfuop_i;
  logic        ex_taken_i;
  logic [31:0] ex_target_i;
  logic [3:0]  ex_ghr_i;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk(clk), .rst(rst), .if_pc_i(if_pc_i),
    .pred_hit_o(pred_hit_o), .pred_taken_o(pred_taken_o),
    .pred_target_o(pred_target_o), .pred_ghr_o(pred_ghr_o),
    .ex_valid_i(ex_valid_i), .ex_pc_i(ex_pc_i), .ex_cfuop_i(ex_cfuop_i),
    .ex_taken_i(ex_taken_i), .ex_target_i(ex_target_i), .ex_ghr_i(ex_ghr_i)
  );

  typedef struct {
    logic        ev;
    logic [3:0]  op;
    logic [31:0] epc;
    logic        tk;
    logic [31:0] etgt;
    logic [3:0]  eghr;
    logic [31:0] lpc;
    logic        hit;
    logic        ptk;
    logic [31:0] ptgt;
    logic [3:0]  ghr;
  } vec_t;

  localparam logic [3:0] NB = 0, BEQ = 1, BNE = 2, BLT = 3, BGEU = 6, JAL = 7, JALR = 8;

  vec_t vecs[28];

  function automatic vec_t mk(logic ev, logic [3:0] op, logic [31:0] epc, logic tk,
                              logic [31:0] etgt, logic [3:0] eghr, logic [31:0] lpc,
                              logic hit, logic ptk, logic [31:0] ptgt, logic [3:0] ghr);
    vec_t v;
    v.ev = ev; v.op = op; v.epc = epc; v.tk = tk; v.etgt = etgt; v.eghr = eghr;
    v.lpc = lpc; v.hit = hit; v.ptk = ptk; v.ptgt = ptgt; v.ghr = ghr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_lookup(input string tag, input logic hit, input logic tk,
                            input logic [31:0] tgt, input logic [3:0] ghr);
    chk({tag, ".hit"},    32'(pred_hit_o),   32'(hit));
    chk({tag, ".taken"},  32'(pred_taken_o), 32'(tk));
    chk({tag, ".target"}, pred_target_o,     tgt);
    chk({tag, ".ghr"},    32'(pred_ghr_o),   32'(ghr));
  endtask

  task automatic drive_upd(input logic ev, input logic [3:0] op, input logic [31:0] pc,
                           input logic tk, input logic [31:0] tgt, input logic [3:0] gh);
    ex_valid_i = ev; ex_cfuop_i = op; ex_pc_i = pc;
    ex_taken_i = tk; ex_target_i = tgt; ex_ghr_i = gh;
  endtask

  initial begin
    //               ev op    epc           tk etgt          eghr  lpc           hit tk  tgt           ghr
    vecs[0]  = mk(0, NB,   32'h100,      0, 32'h0,        4'h0, 32'h100,      0, 0, 32'h104,      4'h0);
    vecs[1]  = mk(1, BEQ,  32'h100,      1, 32'h80,       4'h0, 32'h100,      1, 1, 32'h80,       4'h1);
    vecs[2]  = mk(0, NB,   32'h0,        0, 32'h0,        4'h0, 32'h104,      0, 0, 32'h108,      4'h1);
    vecs[3]  = mk(1, BNE,  32'h200,      1, 32'h240,      4'h1, 32'h200,      1, 1, 32'h240,      4'h3);
    vecs[4]  = mk(1, BNE,  32'h200,      0, 32'h0,        4'h3, 32'h200,      1, 0, 32'h204,      4'h6);
    vecs[5]  = mk(1, BNE,  32'h200,      0, 32'h0,        4'h6, 32'h200,      1, 0, 32'h204,      4'hC);
    vecs[6]  = mk(1, BNE,  32'h200,      0, 32'h0,        4'hC, 32'h200,      1, 0, 32'h204,      4'h8);
    vecs[7]  = mk(1, BNE,  32'h200,      1, 32'h260,      4'h8, 32'h200,      1, 0, 32'h204,      4'h1);
    vecs[8]  = mk(1, BNE,  32'h200,      1, 32'h260,      4'h1, 32'h200,      1, 1, 32'h260,      4'h3);
    vecs[9]  = mk(1, BNE,  32'h200,      1, 32'h260,      4'h3, 32'h200,      1, 1, 32'h260,      4'h7);
    vecs[10] = mk(1, BNE,  32'h200,      1, 32'h260,      4'h7, 32'h200,      1, 1, 32'h260,      4'hF);
    vecs[11] = mk(1, BNE,  32'h200,      0, 32'h0,        4'hF, 32'h200,      1, 1, 32'h260,      4'hE);
    vecs[12] = mk(1, JAL,  32'h300,      1, 32'h1000,     4'hE, 32'h300,      1, 1, 32'h1000,     4'hE);
    vecs[13] = mk(1, BEQ,  32'h300,      0, 32'h0,        4'hE, 32'h300,      1, 1, 32'h1000,     4'hC);
    vecs[14] = mk(1, BEQ,  32'h300,      0, 32'h0,        4'hC, 32'h300,      1, 1, 32'h1000,     4'h8);
    vecs[15] = mk(1, BEQ,  32'h300,      0, 32'h0,        4'h8, 32'h300,      1, 1, 32'h1000,     4'h0);
    vecs[16] = mk(1, BEQ,  32'h300,      0, 32'h0,        4'h0, 32'h300,      1, 1, 32'h1000,     4'h0);
    vecs[17] = mk(0, NB,   32'h0,        0, 32'h0,        4'h0, 32'h200,      0, 0, 32'h204,      4'h0);
    vecs[18] = mk(1, BEQ,  32'h100,      1, 32'h80,       4'h0, 32'h100,      1, 1, 32'h80,       4'h1);
    vecs[19] = mk(1, BEQ,  32'h140,      1, 32'h90,       4'h1, 32'h100,      0, 0, 32'h104,      4'h3);
    vecs[20] = mk(0, NB,   32'h0,        0, 32'h0,        4'h0, 32'h140,      1, 1, 32'h90,       4'h3);
    vecs[21] = mk(1, NB,   32'h140,      1, 32'h999,      4'h0, 32'h140,      1, 1, 32'h90,       4'h3);
    vecs[22] = mk(1, 4'd9, 32'h140,      1, 32'h999,      4'h0, 32'h140,      1, 1, 32'h90,       4'h3);
    vecs[23] = mk(0, BEQ,  32'h180,      1, 32'h777,      4'h0, 32'h180,      0, 0, 32'h184,      4'h3);
    vecs[24] = mk(1, JALR, 32'h8,        1, 32'hFFFFFFF0, 4'h0, 32'h8,        1, 1, 32'hFFFFFFF0, 4'h3);
    vecs[25] = mk(1, BGEU, 32'hC,        0, 32'h0,        4'h3, 32'hC,        0, 0, 32'h10,       4'h6);
    vecs[26] = mk(0, NB,   32'h0,        0, 32'h0,        4'h0, 32'hFFFFFFFC, 0, 0, 32'h0,        4'h6);
    vecs[27] = mk(1, BLT,  32'h10,       1, 32'h20,       4'h6, 32'h10,       1, 1, 32'h20,       4'hD);

    rst = 1'b1;
    if_pc_i = 32'h100;
    drive_upd(0, NB, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 28; i++) begin
      drive_upd(vecs[i].ev, vecs[i].op, vecs[i].epc, vecs[i].tk, vecs[i].etgt, vecs[i].eghr);
      if_pc_i = vecs[i].lpc;
      @(posedge clk);
      #1 ex_valid_i = 1'b0;
      @(negedge clk);
      $display("vec %0d op=%0d epc=%h tk=%0b look=%h -> hit=%0b taken=%0b tgt=%h ghr=%h",
               i, vecs[i].op, vecs[i].epc, vecs[i].tk, vecs[i].lpc,
               pred_hit_o, pred_taken_o, pred_target_o, pred_ghr_o);
      chk_lookup($sformatf("vec%0d", i), vecs[i].hit, vecs[i].ptk, vecs[i].ptgt, vecs[i].ghr);
    end

    // Reset asserted together with an update: reset must win
    rst = 1'b1;
    drive_upd(1, BLT, 32'h10, 1, 32'h30, 4'h6);
    if_pc_i = 32'h10;
    @(posedge clk);
    #1 rst = 1'b0;
    ex_valid_i = 1'b0;
    @(negedge clk);
    $display("rst+upd look=%h -> hit=%0b taken=%0b tgt=%h ghr=%h",
             if_pc_i, pred_hit_o, pred_taken_o, pred_target_o, pred_ghr_o);
    chk_lookup("rst_override", 1'b0, 1'b0, 32'h14, 4'h0);
    if_pc_i = 32'h8;
    #1 chk_lookup("rst_clears_jalr", 1'b0, 1'b0, 32'hC, 4'h0);

    // Same-cycle lookup and update: old state now, new state next cycle
    @(posedge clk);
    #1 drive_upd(1, BEQ, 32'h100, 1, 32'h80, 4'h0);
    if_pc_i = 32'h100;
    #1 $display("same-cycle pre look=%h -> hit=%0b tgt=%h", if_pc_i, pred_hit_o, pred_target_o);
    chk_lookup("same_cycle_pre", 1'b0, 1'b0, 32'h104, 4'h0);
    @(posedge clk);
    #1 ex_valid_i = 1'b0;
    $display("same-cycle post look=%h -> hit=%0b tgt=%h", if_pc_i, pred_hit_o, pred_target_o);
    chk_lookup("same_cycle_post", 1'b1, 1'b1, 32'h80, 4'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter XLEN, default 32: data and address width.
REQ-002 Parameter ENTRIES, default 16: number of BTB/BHT entries; power of two, at least 2.
REQ-003 Parameter CNTR_BITS, default 2: width of each saturating counter, at least 1.
REQ-004 Parameter GHR_BITS, default 4: width of the global history register; at most log2(ENTRIES).
REQ-005 Parameter GSHARE, default 0: 0 selects bimodal indexing, 1 selects gshare indexing.
REQ-006 clk, input, 1: the single clock; all state updates on its rising edge.
REQ-007 rst, input, 1: reset, synchronous and active-high.
REQ-008 if_pc_i, input, XLEN: fetch PC to predict.
REQ-009 pred_hit_o, output, 1: BTB tag hit for if_pc_i.
REQ-010 pred_taken_o, output, 1: predicted taken.
REQ-011 pred_target_o, output, XLEN: predicted target.
REQ-012 pred_ghr_o, output, GHR_BITS: GHR snapshot used for this lookup; the pipeline carries it to execute.
REQ-013 ex_valid_i, input, 1: resolution event valid.
REQ-014 ex_pc_i, input, XLEN: PC of the resolved instruction.
REQ-015 ex_cfuop_i, input, 4: control-flow op encoding (cfu_pkg::cfuop_t: NB, BEQ..BGEU, JAL, JALR).
REQ-016 ex_taken_i, input, 1: actual outcome.
REQ-017 ex_target_i, input, XLEN: actual target.
REQ-018 ex_ghr_i, input, GHR_BITS: pred_ghr_o value returned with the instruction.

Function
REQ-019 IW = log2(ENTRIES); the lookup uses index pc[IW+1:2] and tag pc[XLEN-1:IW+2].
REQ-020 When GSHARE=1, the low GHR_BITS index bits are XORed with the GHR (lookup) or with ex_ghr_i (update); the tag is unchanged.
REQ-021 Each entry holds: valid, tag, target (XLEN), is_jump, and a counter (CNTR_BITS).
REQ-022 Lookup is combinational with zero latency: pred_hit_o = valid && tag match.
REQ-023 pred_taken_o = pred_hit_o && (is_jump || counter MSB == 1).
REQ-024 pred_target_o = the entry target when pred_taken_o = 1, else if_pc_i + 4 (mod 2^XLEN).
REQ-025 pred_ghr_o = the current GHR register value.
REQ-026 Updates commit only on a clock edge with ex_valid_i=1 and ex_cfuop_i != NB; any other cycle leaves state unchanged.
REQ-027 Conditional branch (BEQ..BGEU), tag hit: the counter saturating-increments if taken and saturating-decrements if not; the target is overwritten with ex_target_i if taken.
REQ-028 Conditional branch, miss, taken: allocate the entry (valid=1, tag, target, is_jump=0) with counter = weakly taken (MSB=1, rest 0).
REQ-029 Conditional branch, miss, not taken: no entry change.
REQ-030 JAL/JALR: allocate or overwrite the entry with is_jump=1 and target = ex_target_i; the counter is unchanged.
REQ-031 GHR updates only for conditional branches: GHR <= {ex_ghr_i[GHR_BITS-2:0], ex_taken_i}, i.e. non-speculative and rebuilt from the returned snapshot.
REQ-032 Jumps do not modify the GHR.
REQ-033 Counter saturation bounds: 0 and 2^CNTR_BITS-1; no wrap-around.
REQ-034 A lookup and an update to the same index in the same cycle: the lookup returns pre-update state; the update is visible to a lookup on the next cycle.
REQ-035 Allocation to an index holding a different valid tag replaces it (direct-mapped, no victim logic).
REQ-036 Undefined ex_cfuop_i encodings (above JALR) are treated as NB.

Reset
REQ-037 While rst=1 at a clock edge: all valid bits = 0, all counters = weakly not-taken (MSB=0, rest 1), GHR = 0; targets and tags are don't-care.
REQ-038 rst overrides any simultaneous update, including one mid-stream.
REQ-039 After reset, with any if_pc_i: pred_hit_o = 0, pred_taken_o = 0, pred_target_o = if_pc_i + 4, pred_ghr_o = 0.

Verification
REQ-040 Reset, then lookup PC 0x100 -> hit=0, taken=0, target=0x104, ghr=0.
REQ-041 Resolve BEQ at 0x100, taken, target 0x80 -> next cycle lookup 0x100: hit=1, taken=1, target=0x80; GHR=0001 (GSHARE=0 for the index).
REQ-042 BNE at 0x200 resolved taken once then not-taken 3x (CNTR_BITS=2) -> counter 10,01,00,00; taken=0 after the first not-taken; hit stays 1.
REQ-043 JAL at 0x300, target 0x1000 -> taken=1, target=0x1000; GHR unchanged; four not-taken BEQ updates at the same PC keep taken=1 (is_jump persists until a conditional branch overwrites... no allocation on miss).
REQ-044 Aliasing with ENTRIES=16: allocate 0x100 then 0x140 (same index) -> lookup 0x100: hit=0, target=0x104.
REQ-045 Same-cycle lookup and update on PC 0x100 after reset -> that cycle hit=0; next cycle hit=1.
